// File: rtl/note_player_pkg.sv
// note_player_pkg: shared field widths, note constants, tone table and FSM/triple types
package note_player_pkg;
  localparam int OCTAVE_BITS = 3;
  localparam int NOTE_BITS = 3;
  localparam int LENGTH_BITS = 3;
  localparam logic [NOTE_BITS-1:0] NOTE_REST = 3'd7;
  localparam logic [OCTAVE_BITS-1:0] MID_OCTAVE = 3'd4;
  localparam logic [LENGTH_BITS-1:0] LEN_MAX = 3'd6;
  localparam int F_CHZ [7] = '{26163, 29366, 32963, 34923, 39200, 44000, 49388};
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
  typedef struct packed {
    logic [OCTAVE_BITS-1:0] octave;
    logic [NOTE_BITS-1:0] note;
    logic [LENGTH_BITS-1:0] length;
  } triple_t;
endpackage

// File: rtl/note_player_if.sv
// note_player_if: sequencer<->player link; master drives start/stop/octave/note/length, slave returns ready/busy/done/speaker
interface note_player_if;
  import note_player_pkg::*;
  logic start;
  logic stop;
  logic [OCTAVE_BITS-1:0] octave;
  logic [NOTE_BITS-1:0] note;
  logic [LENGTH_BITS-1:0] length;
  logic ready;
  logic busy;
  logic done;
  logic speaker;
  modport master(output start, stop, octave, note, length, input ready, busy, done, speaker);
  modport slave(input start, stop, octave, note, length, output ready, busy, done, speaker);
endinterface

// File: rtl/note_player_tone_period_lut.sv
// note_player_tone_period_lut: combinational (i_octave, i_note) -> o_hp tone half-period in clk cycles, clamped to >= 2
module note_player_tone_period_lut import note_player_pkg::*; #(
  parameter int CLK_HZ = 100_000_000,
  parameter int HP_BITS = 24
) (
  input  logic [OCTAVE_BITS-1:0] i_octave,
  input  logic [NOTE_BITS-1:0]   i_note,
  output logic [HP_BITS-1:0]     o_hp
);
  localparam logic [63:0] K = 64'(CLK_HZ) * 64'd50;
  localparam logic [63:0] BASE [8] = '{
    K / 64'(F_CHZ[0]), K / 64'(F_CHZ[1]), K / 64'(F_CHZ[2]), K / 64'(F_CHZ[3]),
    K / 64'(F_CHZ[4]), K / 64'(F_CHZ[5]), K / 64'(F_CHZ[6]), 64'd2
  };
  logic [63:0] w_sh;
  always_comb begin
    w_sh = i_octave < MID_OCTAVE ? BASE[i_note] << (MID_OCTAVE - i_octave)
                                 : BASE[i_note] >> (i_octave - MID_OCTAVE);
    o_hp = w_sh < 64'd2 ? HP_BITS'(2) : HP_BITS'(w_sh);
  end
endmodule

// File: rtl/note_player.sv
// note_player: plays one latched {octave,note,length} as a square wave then a silent gap; ports clk, rst_n, bus (slave: start/stop/triple in, ready/busy/done/speaker out)
module note_player import note_player_pkg::*; #(
  parameter int CLK_HZ = 100_000_000,
  parameter int UNIT_MS = 62,
  parameter int GAP_MS = 10,
  parameter int HP_BITS = 24
) (
  input logic clk,
  input logic rst_n,
  note_player_if.slave bus
);
  localparam int PRE_N = CLK_HZ / 1000;
  localparam int PRE_W = $clog2(PRE_N) > 0 ? $clog2(PRE_N) : 1;
  localparam int DUR_MAX = (UNIT_MS << 6) > GAP_MS ? (UNIT_MS << 6) : GAP_MS;
  localparam int MS_W = $clog2(DUR_MAX + 1);
  state_t r_state, w_next;
  triple_t r_trip;
  logic [PRE_W-1:0] r_pre;
  logic [MS_W-1:0] r_ms, w_target;
  logic [HP_BITS-1:0] r_hc, w_hp;
  logic [LENGTH_BITS-1:0] w_len;
  logic r_spk, r_done, w_tick, w_last, w_accept, w_rest;
  note_player_tone_period_lut #(.CLK_HZ(CLK_HZ), .HP_BITS(HP_BITS)) u_lut (
    .i_octave(r_trip.octave),
    .i_note(r_trip.note),
    .o_hp(w_hp)
  );
  always_comb begin
    w_accept = r_state == S_IDLE && bus.start && !bus.stop;
    w_tick = r_pre == PRE_W'(PRE_N - 1);
    w_len = r_trip.length > LEN_MAX ? LEN_MAX : r_trip.length;
    w_target = r_state == S_PLAY ? MS_W'(UNIT_MS << w_len) : MS_W'(GAP_MS);
    w_last = w_tick && r_ms + MS_W'(1) == w_target;
    w_rest = r_trip.note == NOTE_REST;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == S_IDLE ? (w_accept ? S_PLAY : S_IDLE) :
             bus.stop ? S_IDLE :
             !w_last ? r_state :
             (r_state == S_PLAY && GAP_MS != 0) ? S_GAP : S_IDLE;
  always_comb begin
    bus.ready = r_state == S_IDLE;
    bus.busy = r_state != S_IDLE;
    bus.done = r_done;
    bus.speaker = r_spk;
  end
  // Prescaler and ms counter sit at zero in IDLE, so an accept always starts from an exact tick boundary.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_trip <= '0;
      r_pre <= '0;
      r_ms <= '0;
      r_hc <= '0;
      r_spk <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_accept) r_trip <= {bus.octave, bus.note, bus.length};
      r_pre <= (r_state == S_IDLE || w_tick) ? '0 : r_pre + PRE_W'(1);
      r_ms <= (r_state == S_IDLE || w_last) ? '0 : w_tick ? r_ms + MS_W'(1) : r_ms;
      r_hc <= r_state == S_PLAY ? (r_hc == w_hp ? HP_BITS'(1) : r_hc + HP_BITS'(1)) :
              w_accept ? HP_BITS'(1) : '0;
      r_spk <= w_accept ? bus.note != NOTE_REST :
               r_state == S_PLAY && w_next == S_PLAY && !w_rest && (r_hc == w_hp ? !r_spk : r_spk);
      // A stop-driven return to IDLE is an abort and must not report completion.
      r_done <= r_state != S_IDLE && w_next == S_IDLE && !bus.stop;
    end
endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed stimulus with a timeline model of note_player checked every cycle plus literal pins
module tb_note_player;
  localparam int CLK_HZ = 100_000;
  localparam int UNIT_MS = 2;
  localparam int GAP_MS = 1;
  localparam int CPM = CLK_HZ / 1000;
  localparam int F [7] = '{26163, 29366, 32963, 34923, 39200, 44000, 49388};
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  int m_k = 0, m_hp = 1, m_play = 0, m_total = 0;
  logic m_rest = 0;
  logic [3:0] e_out, g_out;
  note_player_if bus();
  note_player #(.CLK_HZ(CLK_HZ), .UNIT_MS(UNIT_MS), .GAP_MS(GAP_MS), .HP_BITS(24)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic int m_hp_of(input int o, input int n);
    int b;
    b = (CLK_HZ * 50) / F[n];
    b = o < 4 ? b << (4 - o) : b >> (o - 4);
    return b < 2 ? 2 : b;
  endfunction
  function automatic int m_dur(input int l);
    return UNIT_MS * CPM * (1 << (l > 6 ? 6 : l));
  endfunction
  // m_k counts cycles since the accept edge: 1..m_play tone, up to m_total gap, m_total+1 the done cycle, 0 idle.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_k <= 0;
    else if ((m_k == 0 || m_k > m_total) && bus.start && !bus.stop) begin
      m_k <= 1;
      m_hp <= bus.note == 3'd7 ? 1 : m_hp_of(int'(bus.octave), int'(bus.note));
      m_rest <= bus.note == 3'd7;
      m_play <= m_dur(int'(bus.length));
      m_total <= m_dur(int'(bus.length)) + GAP_MS * CPM;
    end
    else if (m_k != 0 && m_k <= m_total && bus.stop) m_k <= 0;
    else if (m_k > m_total) m_k <= 0;
    else if (m_k > 0) m_k <= m_k + 1;
  always @(negedge clk)
    if (rst_n) begin
      e_out[3] = !(m_k >= 1 && m_k <= m_total);
      e_out[2] = m_k >= 1 && m_k <= m_total;
      e_out[1] = m_k != 0 && m_k == m_total + 1;
      e_out[0] = m_k >= 1 && m_k <= m_play && !m_rest && ((m_k - 1) / m_hp) % 2 == 0;
      g_out = {bus.ready, bus.busy, bus.done, bus.speaker};
      total++;
      if (g_out !== e_out) begin
        bad++;
        $display("FAIL outs t=%0t k=%0d got rbds=%b exp=%b", $time, m_k, g_out, e_out);
      end
    end
  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask
  task automatic launch(input logic [2:0] o, input logic [2:0] n, input logic [2:0] l);
    @(posedge clk);
    #2 bus.octave = o; bus.note = n; bus.length = l; bus.start = 1;
    @(posedge clk);
    #2 bus.start = 0;
  endtask
  task automatic observe(input string nm, input int exp_run, input int exp_busy, input int chg_at,
                         input logic [2:0] co, input logic [2:0] cn, input logic [2:0] cl);
    int c = 0, nb = 0, run = 0;
    logic inrun = 1, seen = 0;
    while (!seen && c < 20000) begin
      @(negedge clk);
      c++;
      if (c == chg_at) begin
        bus.octave = co; bus.note = cn; bus.length = cl;
      end
      nb += int'(bus.busy);
      if (inrun && bus.speaker) run++;
      else inrun = 0;
      seen = bus.done;
    end
    check({nm, "_busy"}, nb, exp_busy);
    check({nm, "_run"}, run, exp_run);
    check({nm, "_done_at"}, c, exp_busy + 1);
  endtask
  task automatic run_note(input string nm, input logic [2:0] o, input logic [2:0] n, input logic [2:0] l,
                          input int exp_run, input int exp_busy);
    launch(o, n, l);
    observe(nm, exp_run, exp_busy, 0, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    check({nm, "_done_pulse"}, int'(bus.done), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int nd;
    bus.start = 0; bus.stop = 0; bus.octave = 0; bus.note = 0; bus.length = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("reset_state", int'({bus.ready, bus.busy, bus.done, bus.speaker}), 4'b1000);
    launch(3'd4, 3'd5, 3'd0);
    repeat (49) @(posedge clk);
    @(negedge clk);
    check("pre_rst_spk", int'(bus.speaker), 1);
    #2 rst_n = 0;
    #1 check("async_rst", int'({bus.ready, bus.busy, bus.done, bus.speaker}), 4'b1000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    run_note("a4", 3'd4, 3'd5, 3'd0, 113, 300);
    run_note("a5", 3'd5, 3'd5, 3'd0, 56, 300);
    run_note("c0", 3'd0, 3'd0, 3'd4, 3056, 3300);
    run_note("b7", 3'd7, 3'd6, 3'd0, 12, 300);
    run_note("rest", 3'd4, 3'd7, 3'd1, 0, 500);
    launch(3'd4, 3'd5, 3'd0);
    repeat (49) @(posedge clk);
    #2 bus.stop = 1;
    @(posedge clk);
    #2 bus.stop = 0;
    check("stop_idle", int'({bus.ready, bus.busy, bus.done, bus.speaker}), 4'b1000);
    nd = 0;
    repeat (400) begin
      @(negedge clk);
      nd += int'(bus.done);
    end
    check("stop_no_done", nd, 0);
    @(posedge clk);
    #2 bus.start = 1; bus.stop = 1;
    @(posedge clk);
    #2 bus.start = 0; bus.stop = 0;
    check("start_stop_block", int'({bus.ready, bus.busy}), 2'b10);
    @(posedge clk);
    #2 bus.octave = 3'd4; bus.note = 3'd5; bus.length = 3'd0; bus.start = 1;
    @(posedge clk);
    #2;
    observe("hold1", 113, 300, 50, 3'd0, 3'd0, 3'd7);
    @(posedge clk);
    #2 bus.start = 0;
    check("reaccept", int'(bus.busy), 1);
    observe("len7", 3056, 12900, 0, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    check("len7_done_pulse", int'(bus.done), 0);
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
